flash_cmd_sequencer: RTL

//  Command-level controller for the StrataFlash bus-cycle engine (flash). Turns one request (read, word program,

---
 rtl/flash_cmd_sequencer_if.sv | 35 +++
 rtl/flash_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_sequencer_if.sv
// Command/response and flash-engine bus signals of flash_cmd_sequencer.
// slave: the sequencer's view; master: user logic plus engine side (e.g. a bench).
interface flash_cmd_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [DATA_W-1:0] rsp_status;
  logic              rsp_err;
  logic              busy;
  logic              bus_go;
  logic              bus_dir;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, bus_rdata, bus_done,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_err, busy,
           bus_go, bus_dir, bus_addr, bus_wdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, bus_rdata, bus_done,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_status, rsp_err, busy,
           bus_go, bus_dir, bus_addr, bus_wdata
  );
endinterface

// File: rtl/flash_cmd_sequencer.sv
// StrataFlash command sequencer: expands read/program/erase/clear requests into engine bus cycles.
// Optional FLASH_STS_PIN_EN: wait on the synchronised NF_STS pin instead of polling the status register.
module flash_cmd_sequencer #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 NF_STS,
  flash_cmd_sequencer_if.slave fl
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_POLL_RD, S_WAIT_RDY, S_RESTORE, S_RESP
`ifdef FLASH_STS_PIN_EN
    , S_STS_WAIT
`endif
  } state_t;

  typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE, OP_CLEAR} op_t;

  localparam logic [1:0] STEP_RESTORE = 2'd3;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [1:0]        step_q, step_d;
  logic [23:0]       tmo_q, tmo_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] bwd_q, bwd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] status_q, status_d;
  logic              err_q, err_d;
  logic              go, ready, tmo_hit, sr_done, to_restore;

  // Write-command byte for each non-poll step of each operation.
  function automatic logic [DATA_W-1:0] cmd_data(input op_t op, input logic [1:0] step,
                                                 input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] d;
    d = DATA_W'(8'hFF);
    case (op)
      OP_PROG:  d = (step == 2'd0) ? DATA_W'(8'h40) : (step == 2'd1) ? wd : DATA_W'(8'h70);
      OP_ERASE: d = (step == 2'd0) ? DATA_W'(8'h20) : (step == 2'd1) ? DATA_W'(8'hD0) : DATA_W'(8'h70);
      OP_CLEAR: d = (step == 2'd0) ? DATA_W'(8'h50) : DATA_W'(8'hFF);
      default:  d = DATA_W'(8'hFF);
    endcase
    return d;
  endfunction

`ifdef FLASH_STS_PIN_EN
  logic sts_meta, sts_sync;
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sts_meta <= 1'b0;
      sts_sync <= 1'b0;
    end else begin
      sts_meta <= NF_STS;
      sts_sync <= sts_meta;
    end
  end
  // Ready already confirmed by STS, so the single SR read always finishes the poll.
  assign sr_done = 1'b1;
`else
  logic unused_sts;
  assign unused_sts = NF_STS;
  assign sr_done    = fl.bus_rdata[7];
`endif

  assign tmo_hit = (tmo_q >= TIMEOUT_CYC);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    step_d     = step_q;
    tmo_d      = tmo_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    bwd_d      = bwd_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    err_d      = err_q;
    go         = 1'b0;
    to_restore = 1'b0;
    ready      = (state_q == S_IDLE) || (state_q == S_RESP);

    case (state_q)
      S_IDLE, S_RESP: begin
        if (fl.cmd_valid) begin
          op_d    = op_t'(fl.cmd_op);
          addr_d  = fl.cmd_addr;
          wdata_d = fl.cmd_wdata;
          step_d  = 2'd0;
          err_d   = 1'b0;
          dir_d   = 1'b0;
          bwd_d   = cmd_data(op_t'(fl.cmd_op), 2'd0, fl.cmd_wdata);
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE, S_RESTORE: begin
        go      = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fl.bus_done) begin
          if (step_q == STEP_RESTORE) begin
            state_d = S_RESP;
          end else if (op_q == OP_READ && step_q == 2'd1) begin
            rdata_d = fl.bus_rdata;
            state_d = S_RESP;
          end else if (op_q == OP_CLEAR && step_q == 2'd1) begin
            state_d = S_RESP;
          end else if (step_q == 2'd2) begin
            tmo_d   = '0;
            dir_d   = 1'b1;
            state_d = S_POLL_RD;
`ifdef FLASH_STS_PIN_EN
          end else if (step_q == 2'd1) begin
            tmo_d   = '0;
            state_d = S_STS_WAIT;
`endif
          end else begin
            step_d  = step_q + 2'd1;
            dir_d   = (op_q == OP_READ);
            bwd_d   = cmd_data(op_q, step_q + 2'd1, wdata_q);
            state_d = S_ISSUE;
          end
        end
      end
      S_POLL_RD: begin
        tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 24'd1;
        if (tmo_hit) begin
          err_d      = 1'b1;
          to_restore = 1'b1;
        end else begin
          go      = 1'b1;
          state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 24'd1;
        // A read already on the bus is always allowed to finish, even past the timeout.
        if (fl.bus_done) begin
          status_d = fl.bus_rdata;
          if (sr_done) begin
            err_d      = |(fl.bus_rdata & DATA_W'(8'h3A));
            to_restore = 1'b1;
          end else if (tmo_hit) begin
            err_d      = 1'b1;
            to_restore = 1'b1;
          end else begin
            state_d = S_POLL_RD;
          end
        end
      end
`ifdef FLASH_STS_PIN_EN
      S_STS_WAIT: begin
        tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 24'd1;
        if (tmo_hit) begin
          err_d      = 1'b1;
          to_restore = 1'b1;
        end else if (tmo_q >= 24'd4 && sts_sync) begin
          step_d  = 2'd2;
          dir_d   = 1'b0;
          bwd_d   = DATA_W'(8'h70);
          state_d = S_ISSUE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (to_restore) begin
      step_d  = STEP_RESTORE;
      dir_d   = 1'b0;
      bwd_d   = DATA_W'(8'hFF);
      state_d = S_RESTORE;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_READ;
      step_q   <= 2'd0;
      tmo_q    <= '0;
      dir_q    <= 1'b1;
      addr_q   <= '0;
      bwd_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= DATA_W'(8'h80);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      step_q   <= step_d;
      tmo_q    <= tmo_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      bwd_q    <= bwd_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      err_q    <= err_d;
    end
  end

  assign fl.cmd_ready  = ready;
  assign fl.busy       = ~ready;
  assign fl.rsp_valid  = (state_q == S_RESP);
  assign fl.rsp_rdata  = rdata_q;
  assign fl.rsp_status = status_q;
  assign fl.rsp_err    = err_q;
  assign fl.bus_go     = go;
  assign fl.bus_dir    = dir_q;
  assign fl.bus_addr   = addr_q;
  assign fl.bus_wdata  = bwd_q;

endmodule
